// File: rtl/dbi_pkg.sv
// Shared definitions for the DBI Type-B write PHY: FSM state encoding,
// DCX meaning and the default cycle timing.
package dbi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WR_L  = 3'd2,
    WR_H  = 3'd3,
    GAP   = 3'd4,
    HOLD  = 3'd5
  } dbi_state_e;

  localparam logic DCX_CMD  = 1'b0;
  localparam logic DCX_DATA = 1'b1;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_CS_SETUP    = 1;
  localparam int DEF_WR_LOW_CYC  = 2;
  localparam int DEF_WR_HIGH_CYC = 2;
  localparam int DEF_CS_HOLD     = 1;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/dbi_typeb_wr_phy.sv
// MIPI DBI Type-B (8080-style) write PHY: turns accepted valid/ready beats
// into CSX/DCX/WRX/D write cycles with programmable setup/strobe/hold timing.
module dbi_typeb_wr_phy
  import dbi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CS_SETUP    = DEF_CS_SETUP,
  parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
  parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC,
  parameter int CS_HOLD     = DEF_CS_HOLD,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] bwd_data_i,
  input  logic                  bwd_dcx_i,
  input  logic                  bwd_last_i,
  input  logic                  bwd_valid_i,
  output logic                  bwd_ready_o,
  output logic                  dbi_csx_o,
  output logic                  dbi_dcx_o,
  output logic                  dbi_wrx_o,
  output logic                  dbi_rdx_o,
  output logic [DATA_WIDTH-1:0] dbi_d_o,
  output logic                  busy_o
);

  if (CS_SETUP < 1 || WR_LOW_CYC < 1 || WR_HIGH_CYC < 1 || CS_HOLD < 1) begin : g_bad_timing
    $error("dbi_typeb_wr_phy: every timing parameter must be at least 1");
  end
  if ((CS_SETUP - 1) >= (1 << CNT_W) || (WR_LOW_CYC - 1) >= (1 << CNT_W) ||
      (WR_HIGH_CYC - 1) >= (1 << CNT_W) || (CS_HOLD - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("dbi_typeb_wr_phy: CNT_W too narrow for the timing parameters");
  end

  // Counter reload values; each phase lasts (reload + 1) clk cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(WR_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);

  dbi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  csx_q, csx_d;
  logic                  wrx_q, wrx_d;
  logic                  dcx_q, dcx_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic                  last_q, last_d;
  logic                  ready;
  logic                  accept;
  logic                  cnt_zero;

  assign cnt_zero = (cnt_q == '0);
  assign ready    = (state_q == IDLE) || (state_q == GAP) ||
                    ((state_q == WR_H) && cnt_zero && !last_q);
  assign accept   = bwd_valid_i && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csx_d   = csx_q;
    wrx_d   = wrx_q;
    dcx_d   = dcx_q;
    d_d     = d_q;
    last_d  = last_q;

    // Payload is captured only on acceptance so D/DCX stay frozen across a strobe.
    if (accept) begin
      d_d    = bwd_data_i;
      dcx_d  = bwd_dcx_i;
      last_d = bwd_last_i;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          csx_d   = 1'b0;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          wrx_d   = 1'b0;
          cnt_d   = LOW_LD;
          state_d = WR_L;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_L: begin
        if (cnt_zero) begin
          wrx_d   = 1'b1;
          cnt_d   = HIGH_LD;
          state_d = WR_H;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_H: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (last_q) begin
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else if (accept) begin
          // CSX is already low, so a follow-on beat skips the setup phase.
          wrx_d   = 1'b0;
          cnt_d   = LOW_LD;
          state_d = WR_L;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (accept) begin
          wrx_d   = 1'b0;
          cnt_d   = LOW_LD;
          state_d = WR_L;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          csx_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        csx_d   = 1'b1;
        wrx_d   = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csx_q   <= 1'b1;
      wrx_q   <= 1'b1;
      dcx_q   <= DCX_DATA;
      d_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csx_q   <= csx_d;
      wrx_q   <= wrx_d;
      dcx_q   <= dcx_d;
      d_q     <= d_d;
      last_q  <= last_d;
    end
  end

  assign bwd_ready_o = ready;
  assign dbi_csx_o   = csx_q;
  assign dbi_wrx_o   = wrx_q;
  assign dbi_dcx_o   = dcx_q;
  assign dbi_d_o     = d_q;
  assign dbi_rdx_o   = 1'b1;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dbi_typeb_wr_phy.sv
// Bench for dbi_typeb_wr_phy: directed and random beats on a default-timing
// instance and a non-default-timing instance, checked by a waveform-rule monitor.
module tb_dbi_typeb_wr_phy;
  import dbi_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic [7:0] bwd_data;
  logic       bwd_dcx, bwd_last, bwd_valid;

  logic       d_ready, d_csx, d_dcx, d_wrx, d_rdx, d_busy;
  logic [7:0] d_d;
  logic       a_ready, a_csx, a_dcx, a_wrx, a_rdx, a_busy;
  logic [7:0] a_d;

  logic       o_ready, o_csx, o_dcx, o_wrx, o_rdx, o_busy;
  logic [7:0] o_d;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int p_setup, p_low, p_high, p_hold;
  beat_t q[$];
  logic last_acc;
  logic prev_csx, prev_wrx;
  int   csx_fall_cyc, wr_fall_cyc, wr_rise_cyc, exp_csx_rise, txn_beats;
  logic have_rise, pre_first, in_tail, hold_chk;
  logic [7:0] ref_d;
  logic       ref_dcx;

  always #5 clk = ~clk;

  dbi_typeb_wr_phy u_def (
    .clk(clk), .rst_n(rst_n),
    .bwd_data_i(bwd_data), .bwd_dcx_i(bwd_dcx), .bwd_last_i(bwd_last),
    .bwd_valid_i(bwd_valid & ~sel), .bwd_ready_o(d_ready),
    .dbi_csx_o(d_csx), .dbi_dcx_o(d_dcx), .dbi_wrx_o(d_wrx), .dbi_rdx_o(d_rdx),
    .dbi_d_o(d_d), .busy_o(d_busy)
  );

  dbi_typeb_wr_phy #(
    .DATA_WIDTH(8), .CS_SETUP(3), .WR_LOW_CYC(1), .WR_HIGH_CYC(4), .CS_HOLD(2), .CNT_W(4)
  ) u_alt (
    .clk(clk), .rst_n(rst_n),
    .bwd_data_i(bwd_data), .bwd_dcx_i(bwd_dcx), .bwd_last_i(bwd_last),
    .bwd_valid_i(bwd_valid & sel), .bwd_ready_o(a_ready),
    .dbi_csx_o(a_csx), .dbi_dcx_o(a_dcx), .dbi_wrx_o(a_wrx), .dbi_rdx_o(a_rdx),
    .dbi_d_o(a_d), .busy_o(a_busy)
  );

  assign o_ready = sel ? a_ready : d_ready;
  assign o_csx   = sel ? a_csx   : d_csx;
  assign o_dcx   = sel ? a_dcx   : d_dcx;
  assign o_wrx   = sel ? a_wrx   : d_wrx;
  assign o_rdx   = sel ? a_rdx   : d_rdx;
  assign o_d     = sel ? a_d     : d_d;
  assign o_busy  = sel ? a_busy  : d_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mon_clear();
    q.delete();
    prev_csx  = 1'b1;
    prev_wrx  = 1'b1;
    have_rise = 1'b0;
    pre_first = 1'b0;
    in_tail   = 1'b0;
    ref_d     = 8'h00;
    ref_dcx   = DCX_DATA;
  endtask

  // Rule-based checks on the sampled waveform, evaluated once per cycle.
  task automatic mon();
    beat_t b;
    logic  exp_rdy;
    chk("rdx_tied", o_rdx, 1'b1);
    chk("busy_vs_csx", o_busy, !o_csx);
    if (prev_csx && !o_csx) begin
      chk("csx_fall_on_accept", last_acc, 1'b1);
      csx_fall_cyc = cyc;
      have_rise = 1'b0;
      pre_first = 1'b1;
      in_tail   = 1'b0;
      txn_beats = 0;
    end
    if (prev_wrx && !o_wrx) begin
      chk("wrx_fall_csx_low", o_csx, 1'b0);
      if (pre_first) chk("setup_len", cyc - csx_fall_cyc, p_setup);
      else if (hold_chk) chk("burst_period", cyc - wr_fall_cyc, p_low + p_high);
      else chk("high_min", (cyc - wr_rise_cyc) >= p_high, 1'b1);
      pre_first   = 1'b0;
      wr_fall_cyc = cyc;
    end
    if (!prev_wrx && o_wrx) begin
      chk("wrx_low_len", cyc - wr_fall_cyc, p_low);
      if (q.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        b = q.pop_front();
        chk("rise_data", o_d, b.d);
        chk("rise_dcx", o_dcx, b.c);
        ref_d   = b.d;
        ref_dcx = b.c;
        txn_beats++;
        if (b.l) begin
          in_tail      = 1'b1;
          exp_csx_rise = cyc + p_high + p_hold;
        end
      end
      wr_rise_cyc = cyc;
      have_rise   = 1'b1;
    end
    if (!prev_csx && o_csx) begin
      chk("csx_rise_after_last", in_tail, 1'b1);
      chk("csx_rise_time", cyc, exp_csx_rise);
      if (txn_beats == 1) chk("csx_low_len", cyc - csx_fall_cyc, p_setup + p_low + p_high + p_hold);
      in_tail = 1'b0;
    end
    if (o_csx) begin
      chk("idle_wrx", o_wrx, 1'b1);
      chk("idle_ready", o_ready, 1'b1);
      chk("idle_d_kept", o_d, ref_d);
      chk("idle_dcx_kept", o_dcx, ref_dcx);
    end else if (!o_wrx) begin
      chk("low_ready", o_ready, 1'b0);
      if (q.size() != 0) begin
        chk("low_d_stable", o_d, q[0].d);
        chk("low_dcx_stable", o_dcx, q[0].c);
      end
    end else begin
      exp_rdy = !in_tail && have_rise && ((cyc - wr_rise_cyc) >= p_high - 1);
      chk("high_ready", o_ready, exp_rdy);
      if (pre_first && q.size() != 0) chk("setup_d", o_d, q[0].d);
      else if (!pre_first) chk("high_d_kept", o_d, ref_d);
    end
    prev_csx = o_csx;
    prev_wrx = o_wrx;
  endtask

  task automatic tick();
    last_acc = bwd_valid && o_ready;
    if (last_acc) q.push_back('{d: bwd_data, c: bwd_dcx, l: bwd_last});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic send(input logic [7:0] d, input logic c, input logic l);
    int n;
    n = 0;
    bwd_valid = 1'b1;
    bwd_data  = d;
    bwd_dcx   = c;
    bwd_last  = l;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 64);
    chk("accept_timeout", last_acc, 1'b1);
    bwd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!o_csx && n < 64) begin
      tick();
      n++;
    end
    chk("idle_timeout", o_csx, 1'b1);
  endtask

  initial begin
    int n;
    int len;
    rst_n = 1'b0; sel = 1'b0;
    bwd_valid = 1'b0; bwd_data = 8'h00; bwd_dcx = 1'b1; bwd_last = 1'b0;
    p_setup = DEF_CS_SETUP; p_low = DEF_WR_LOW_CYC; p_high = DEF_WR_HIGH_CYC; p_hold = DEF_CS_HOLD;
    hold_chk = 1'b0; last_acc = 1'b0;
    csx_fall_cyc = 0; wr_fall_cyc = 0; wr_rise_cyc = 0; exp_csx_rise = 0; txn_beats = 0;
    mon_clear();

    // Reset, then idle with valid low
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rst_csx", o_csx, 1'b1);
    chk("rst_wrx", o_wrx, 1'b1);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_d", o_d, 8'h00);
    chk("rst_dcx", o_dcx, 1'b1);

    // Single command beat
    send(8'h2C, DCX_CMD, 1'b1);
    chk("single_busy", o_busy, 1'b1);
    chk("single_ready_t1", o_ready, 1'b0);
    wait_idle();
    chk("single_d_kept", o_d, 8'h2C);
    chk("single_dcx_kept", o_dcx, DCX_CMD);

    // Four-beat burst with valid held
    hold_chk = 1'b1;
    send(8'h11, DCX_DATA, 1'b0);
    send(8'h22, DCX_DATA, 1'b0);
    send(8'h33, DCX_DATA, 1'b0);
    send(8'h44, DCX_DATA, 1'b1);
    wait_idle();
    hold_chk = 1'b0;
    chk("burst_drained", q.size(), 0);

    // Valid gap parks the PHY in GAP with CSX low
    send(8'hA5, DCX_DATA, 1'b0);
    repeat (10) tick();
    chk("gap_csx", o_csx, 1'b0);
    chk("gap_wrx", o_wrx, 1'b1);
    chk("gap_ready", o_ready, 1'b1);
    send(8'h5A, DCX_DATA, 1'b1);
    wait_idle();
    chk("gap_d_kept", o_d, 8'h5A);

    // Asynchronous reset in the middle of a strobe
    bwd_valid = 1'b1; bwd_data = 8'h77; bwd_dcx = DCX_CMD; bwd_last = 1'b0;
    n = 0;
    while (o_wrx && n < 20) begin
      tick();
      n++;
    end
    chk("reach_wr_l", o_wrx, 1'b0);
    bwd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_csx", o_csx, 1'b1);
    chk("arst_wrx", o_wrx, 1'b1);
    chk("arst_d", o_d, 8'h00);
    chk("arst_dcx", o_dcx, 1'b1);
    chk("arst_busy", o_busy, 1'b0);
    mon_clear();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(8'hE1, DCX_DATA, 1'b1);
    wait_idle();
    chk("post_rst_d", o_d, 8'hE1);

    // Random transactions
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        send(8'($urandom), 1'($urandom), (k == len - 1));
        repeat ($urandom_range(0, 3)) tick();
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    chk("random_drained", q.size(), 0);

    // Non-default timing instance
    sel = 1'b1;
    p_setup = 3; p_low = 1; p_high = 4; p_hold = 2;
    mon_clear();
    tick();
    send(8'hC3, DCX_DATA, 1'b1);
    wait_idle();
    chk("alt_d_kept", o_d, 8'hC3);
    send(8'h3C, DCX_CMD, 1'b0);
    send(8'h96, DCX_DATA, 1'b1);
    wait_idle();
    chk("alt_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
